// File: rtl/ctrl_pipe.sv
// Pipeline control sequencer: carries the decoded control bundle through ID/EX, EX/MEM
// and MEM/WB, and generates load-use/branch stalls, IF/ID flushes and EX forward selects.
module ctrl_pipe (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ctrl_i,
    input  logic       branch_i,
    input  logic       eq_i,
    input  logic       jump_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic [4:0] rd_i,
    output logic       ex_alusrc_o,
    output logic [1:0] ex_aluop_o,
    output logic       ex_regdst_o,
    output logic [1:0] forward_a_o,
    output logic [1:0] forward_b_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       wb_regwrite_o,
    output logic       wb_memtoreg_o,
    output logic [4:0] wb_dest_o,
    output logic       stall_o,
    output logic       flush_o
);

    localparam int C_ALUSRC   = 0;
    localparam int C_REGDST   = 3;
    localparam int C_MEMREAD  = 4;
    localparam int C_MEMWRITE = 5;
    localparam int C_REGWRITE = 6;
    localparam int C_MEMTOREG = 7;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
    } id_ex_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       memtoreg;
        logic [4:0] dest;
    } ex_mem_t;

    typedef struct packed {
        logic       reg_write;
        logic       memtoreg;
        logic [4:0] dest;
    } mem_wb_t;

    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic load_use, br_stall, stall, flush;

    // $0 is hardwired, so a zero destination never creates a dependency.
    function automatic logic dep_hit(input logic [4:0] dest, input logic [4:0] a,
                                     input logic [4:0] b);
        return (dest != 5'd0) && ((dest == a) || (dest == b));
    endfunction

    // The younger producer (EX/MEM) holds the newer value and takes priority.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input ex_mem_t em,
                                           input mem_wb_t mw);
        logic [1:0] sel;
        sel = 2'b00;
        if (em.reg_write && em.dest != 5'd0 && em.dest == src)
            sel = 2'b10;
        else if (mw.reg_write && mw.dest != 5'd0 && mw.dest == src)
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        load_use = id_ex_q.ctrl[C_MEMREAD] & dep_hit(id_ex_q.dest, rs_i, rt_i);
        br_stall = branch_i &
                   ((id_ex_q.ctrl[C_REGWRITE] & dep_hit(id_ex_q.dest, rs_i, rt_i)) |
                    (ex_mem_q.mem_read & dep_hit(ex_mem_q.dest, rs_i, rt_i)));
        stall    = ~rst_i & (load_use | br_stall);
        // A stalled branch re-resolves next cycle, so it must not flush yet.
        flush    = ~rst_i & ~stall & ((branch_i & eq_i) | jump_i);
    end

    always_comb begin
        id_ex_d = '0;
        if (!(stall || branch_i || jump_i)) begin
            id_ex_d.ctrl = ctrl_i;
            id_ex_d.dest = ctrl_i[C_REGDST] ? rd_i : rt_i;
            id_ex_d.rs   = rs_i;
            id_ex_d.rt   = rt_i;
        end

        ex_mem_d.mem_read  = id_ex_q.ctrl[C_MEMREAD];
        ex_mem_d.mem_write = id_ex_q.ctrl[C_MEMWRITE];
        ex_mem_d.reg_write = id_ex_q.ctrl[C_REGWRITE];
        ex_mem_d.memtoreg  = id_ex_q.ctrl[C_MEMTOREG];
        ex_mem_d.dest      = id_ex_q.dest;

        mem_wb_d.reg_write = ex_mem_q.reg_write;
        mem_wb_d.memtoreg  = ex_mem_q.memtoreg;
        mem_wb_d.dest      = ex_mem_q.dest;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    always_comb begin
        ex_alusrc_o   = id_ex_q.ctrl[C_ALUSRC];
        ex_aluop_o    = id_ex_q.ctrl[2:1];
        ex_regdst_o   = id_ex_q.ctrl[C_REGDST];
        forward_a_o   = fwd_sel(id_ex_q.rs, ex_mem_q, mem_wb_q);
        forward_b_o   = fwd_sel(id_ex_q.rt, ex_mem_q, mem_wb_q);
        mem_read_o    = ex_mem_q.mem_read;
        mem_write_o   = ex_mem_q.mem_write;
        wb_regwrite_o = mem_wb_q.reg_write;
        wb_memtoreg_o = mem_wb_q.memtoreg;
        wb_dest_o     = mem_wb_q.dest;
        stall_o       = stall;
        flush_o       = flush;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: a directed vector table for the hazard corner cases, then
// randomized traffic checked against an instruction-history model.
module tb_ctrl_pipe;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] ctrl_i;
    logic       branch_i, eq_i, jump_i;
    logic [4:0] rs_i, rt_i, rd_i;
    logic       ex_alusrc_o, ex_regdst_o;
    logic [1:0] ex_aluop_o, forward_a_o, forward_b_o;
    logic       mem_read_o, mem_write_o, wb_regwrite_o, wb_memtoreg_o;
    logic [4:0] wb_dest_o;
    logic       stall_o, flush_o;

    always #5 clk_i = ~clk_i;

    ctrl_pipe dut (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .branch_i(branch_i), .eq_i(eq_i),
        .jump_i(jump_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .ex_alusrc_o(ex_alusrc_o), .ex_aluop_o(ex_aluop_o), .ex_regdst_o(ex_regdst_o),
        .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .wb_regwrite_o(wb_regwrite_o), .wb_memtoreg_o(wb_memtoreg_o), .wb_dest_o(wb_dest_o),
        .stall_o(stall_o), .flush_o(flush_o)
    );

    typedef struct {
        logic        rst;
        logic [7:0]  ctrl;
        logic        br, eq, j;
        logic [4:0]  rs, rt, rd;
        logic        chk;
        logic [18:0] exp;
    } vec_t;

    // One instruction as it entered EX; later stages are the same record, older.
    typedef struct {
        logic [7:0] ctrl;
        logic [4:0] dest, rs, rt;
    } minst_t;

    vec_t   vecs[$];
    minst_t hist[3];   // [0] = in EX, [1] = in MEM, [2] = in WB
    int     n_tests = 0;
    int     n_fail  = 0;

    function automatic logic [18:0] pk(input logic as, input logic [1:0] op, input logic rd,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic mr, input logic mw, input logic rw,
                                       input logic m2r, input logic [4:0] dst,
                                       input logic st, input logic fl);
        return {as, op, rd, fa, fb, mr, mw, rw, m2r, dst, st, fl};
    endfunction

    task automatic addv(input logic rst, input logic [7:0] ctrl, input logic br, input logic eq,
                        input logic j, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic chk, input logic [18:0] exp);
        vec_t v;
        v.rst = rst; v.ctrl = ctrl; v.br = br; v.eq = eq; v.j = j;
        v.rs = rs; v.rt = rt; v.rd = rd; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endtask

    function automatic logic uses(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        return d != 0 && (d == a || d == b);
    endfunction

    function automatic logic [1:0] mfwd(input logic [4:0] src);
        if (hist[1].ctrl[6] && hist[1].dest != 0 && hist[1].dest == src) return 2'b10;
        if (hist[2].ctrl[6] && hist[2].dest != 0 && hist[2].dest == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [18:0] model_out(input vec_t v);
        logic ld, bs, st, fl;
        ld = hist[0].ctrl[4] && uses(hist[0].dest, v.rs, v.rt);
        bs = v.br && ((hist[0].ctrl[6] && uses(hist[0].dest, v.rs, v.rt)) ||
                      (hist[1].ctrl[4] && uses(hist[1].dest, v.rs, v.rt)));
        st = !v.rst && (ld || bs);
        fl = !v.rst && !st && ((v.br && v.eq) || v.j);
        return pk(hist[0].ctrl[0], hist[0].ctrl[2:1], hist[0].ctrl[3],
                  mfwd(hist[0].rs), mfwd(hist[0].rt),
                  hist[1].ctrl[4], hist[1].ctrl[5], hist[2].ctrl[6], hist[2].ctrl[7],
                  hist[2].dest, st, fl);
    endfunction

    task automatic model_step(input vec_t v, input logic st);
        minst_t bub, nx;
        bub = '{ctrl: 8'h00, dest: 5'd0, rs: 5'd0, rt: 5'd0};
        nx  = '{ctrl: v.ctrl, dest: (v.ctrl[3] ? v.rd : v.rt), rs: v.rs, rt: v.rt};
        if (v.rst) begin
            hist[0] = bub; hist[1] = bub; hist[2] = bub;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (st || v.br || v.j) ? bub : nx;
        end
    endtask

    task automatic apply(input vec_t v, input logic use_model, input string nm, input int idx,
                         output logic st);
        logic [18:0] exp, act;
        rst_i = v.rst; ctrl_i = v.ctrl; branch_i = v.br; eq_i = v.eq; jump_i = v.j;
        rs_i = v.rs; rt_i = v.rt; rd_i = v.rd;
        #1;
        exp = use_model ? model_out(v) : v.exp;
        act = {ex_alusrc_o, ex_aluop_o, ex_regdst_o, forward_a_o, forward_b_o,
               mem_read_o, mem_write_o, wb_regwrite_o, wb_memtoreg_o, wb_dest_o,
               stall_o, flush_o};
        if (v.chk) begin
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s[%0d] got %05h want %05h (stall %b/%b flush %b/%b)",
                         nm, idx, act, exp, act[1], exp[1], act[0], exp[0]);
            end
        end
        st = exp[1];
        model_step(v, use_model ? exp[1] : model_out(v) >> 1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [18:0] z;
        logic        st;
        vec_t        v;
        z = '0;
        // reset with all-ones bundle, then lw $2 / dependent add
        addv(1, 8'hFF, 0, 0, 0,  0,  0,  0, 0, z);
        addv(1, 8'hFF, 0, 0, 0,  0,  0,  0, 1, z);
        addv(0, 8'hD1, 0, 0, 0,  1,  2,  0, 1, z);
        addv(0, 8'h4E, 0, 0, 0,  2,  4,  3, 1, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        addv(0, 8'h4E, 0, 0, 0,  2,  4,  3, 1, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        addv(0, 8'h4E, 0, 0, 0,  7,  8,  5, 1, pk(0, 3, 1, 1, 0, 0, 0, 1, 1, 2, 0, 0));
        // add $5 -> sub $9,$5 -> independent -> writer of $0 -> reader of $0
        addv(0, 8'h4E, 0, 0, 0,  5,  1,  9, 1, pk(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        addv(0, 8'h4E, 0, 0, 0, 11, 12, 13, 1, pk(0, 3, 1, 2, 0, 0, 0, 1, 0, 3, 0, 0));
        addv(0, 8'h4E, 0, 0, 0,  9,  0,  0, 1, pk(0, 3, 1, 0, 0, 0, 0, 1, 0, 5, 0, 0));
        addv(0, 8'h4E, 0, 0, 0,  0,  0, 14, 1, pk(0, 3, 1, 1, 0, 0, 0, 1, 0, 9, 0, 0));
        // add $6 then beq $6,$7 taken, then beq not taken, then jump
        addv(0, 8'h4E, 0, 0, 0,  1,  1,  6, 1, pk(0, 3, 1, 0, 0, 0, 0, 1, 0, 13, 0, 0));
        addv(0, 8'h02, 1, 1, 0,  6,  7,  0, 1, pk(0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        addv(0, 8'h02, 1, 1, 0,  6,  7,  0, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 14, 0, 1));
        addv(0, 8'h02, 1, 0, 0,  6,  7,  0, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0));
        addv(0, 8'hFF, 0, 0, 1,  6,  7,  6, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // lw/add stall interrupted by reset
        addv(0, 8'hD1, 0, 0, 0,  1,  2,  0, 1, z);
        addv(1, 8'h4E, 0, 0, 0,  2,  4,  3, 1, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        addv(0, 8'h4E, 0, 0, 0,  2,  4,  3, 1, z);
        addv(0, 8'h4E, 0, 0, 0,  1,  1, 20, 1, pk(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // lw $2 then beq $2,$5: two stall cycles, then flush
        addv(0, 8'hD1, 0, 0, 0,  1,  2,  0, 1, pk(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        addv(0, 8'h02, 1, 1, 0,  2,  5,  0, 1, pk(1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0));
        addv(0, 8'h02, 1, 1, 0,  2,  5,  0, 1, pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 20, 1, 0));
        addv(0, 8'h02, 1, 1, 0,  2,  5,  0, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 1));
        addv(0, 8'h00, 0, 0, 0,  0,  0,  0, 1, z);

        foreach (vecs[i]) apply(vecs[i], 1'b0, "vec", i, st);

        // Random phase: resync the model with an unchecked reset cycle first.
        v = '{rst: 1, ctrl: 8'h00, br: 0, eq: 0, j: 0, rs: 0, rt: 0, rd: 0, chk: 0, exp: z};
        apply(v, 1'b1, "rnd", -1, st);
        v.chk = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!(st && $urandom_range(0, 3) != 0)) begin
                int kind;
                kind   = $urandom_range(0, 9);
                v.br   = (kind == 6);
                v.j    = (kind == 7);
                v.eq   = 1'($urandom_range(0, 1));
                v.rs   = 5'($urandom_range(0, 7));
                v.rt   = 5'($urandom_range(0, 7));
                v.rd   = 5'($urandom_range(0, 7));
                case (kind)
                    0, 1, 2: v.ctrl = 8'h4E;
                    3, 4:    v.ctrl = 8'hD1;
                    5:       v.ctrl = 8'h21;
                    9:       v.ctrl = 8'h00;
                    default: v.ctrl = 8'($urandom);
                endcase
            end
            v.rst = ($urandom_range(0, 63) == 0);
            apply(v, 1'b1, "rnd", i, st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
